fifo_burst_ctrl: RTL

- Sequences the filter-output dual-width FIFO (16-bit write port, 8-bit read port, standard-mode read with 1-cycle dout latency).
- Fill phase: writes each filtered sample into the FIFO until it is full, or until a drain is requested.
- Drain phase: reads bytes back at a paced rate and hands each one to the downstream byte transmitter over a valid/ready handshake, then returns to fill.
- Single clock domain (clk_out1); the FIFO's wr_clk and rd_clk are both tied to clk_out1 by the parent.

---
 rtl/fifo_burst_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_burst_ctrl.sv
// Fill/drain sequencer for a 16-bit-in / 8-bit-out FIFO feeding a paced
// byte transmitter over a valid/ready handshake.
module fifo_burst_ctrl #(
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned DOUT_W = 8,
  parameter int unsigned PACE   = 190,
  parameter int unsigned CNT_W  = 21
) (
  input  logic              clk_out1,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DIN_W-1:0]  sample_data,
  input  logic              drain_req,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic              fifo_wr_rst_busy,
  input  logic              fifo_rd_rst_busy,
  input  logic [DOUT_W-1:0] fifo_dout,
  output logic [DIN_W-1:0]  fifo_din,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  input  logic              tx_ready,
  output logic [DOUT_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              send1,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN_WAIT,
    DRAIN_READ,
    DRAIN_LATCH,
    DRAIN_SEND
  } state_t;

  localparam logic [CNT_W-1:0] PACE_LAST = CNT_W'(PACE - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  pace_cnt, pace_nxt, pace_inc;
  logic              send1_nxt, tx_valid_nxt;
  logic [DOUT_W-1:0] tx_data_nxt;
  logic [7:0]        drop_nxt;
  logic              rst_busy, drop;

  assign rst_busy   = fifo_wr_rst_busy | fifo_rd_rst_busy;
  assign fifo_din   = sample_data;
  assign fifo_wr_en = (state == FILL) & sample_valid & ~fifo_full;
  assign fifo_rd_en = (state == DRAIN_READ) & ~rst_busy;
  assign drop       = sample_valid & ~fifo_wr_en & (state != IDLE);

  // Counter parks at PACE-1 so a long tx_ready stall cannot wrap it.
  assign pace_inc = (pace_cnt == PACE_LAST) ? pace_cnt : pace_cnt + CNT_W'(1);

  always_comb begin
    state_nxt    = state;
    pace_nxt     = pace_cnt;
    send1_nxt    = send1;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    drop_nxt     = (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;

    if (state != IDLE && rst_busy) begin
      state_nxt    = IDLE;
      send1_nxt    = 1'b0;
      tx_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rst_busy) state_nxt = FILL;
        end
        FILL: begin
          if (fifo_full || (drain_req && !fifo_empty)) begin
            state_nxt = DRAIN_WAIT;
            send1_nxt = 1'b1;
            pace_nxt  = '0;
          end
        end
        DRAIN_WAIT: begin
          pace_nxt = pace_inc;
          if (fifo_empty) begin
            state_nxt = FILL;
            send1_nxt = 1'b0;
          end else if (pace_cnt == PACE_LAST) begin
            state_nxt = DRAIN_READ;
            pace_nxt  = '0;
          end
        end
        DRAIN_READ: begin
          pace_nxt  = pace_inc;
          state_nxt = DRAIN_LATCH;
        end
        DRAIN_LATCH: begin
          pace_nxt     = pace_inc;
          tx_data_nxt  = fifo_dout;
          tx_valid_nxt = 1'b1;
          state_nxt    = DRAIN_SEND;
        end
        DRAIN_SEND: begin
          pace_nxt = pace_inc;
          if (tx_ready) begin
            tx_valid_nxt = 1'b0;
            if (pace_cnt == PACE_LAST && !fifo_empty) begin
              state_nxt = DRAIN_READ;
              pace_nxt  = '0;
            end else begin
              state_nxt = DRAIN_WAIT;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_out1 or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pace_cnt <= '0;
      send1    <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pace_cnt <= pace_nxt;
      send1    <= send1_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      drop_cnt <= drop_nxt;
    end
  end

endmodule
